dmx_tx_engine: RTL and testbench
================================

Name: dmx_tx_engine

Overview:
- Next-generation DMX512 transmitter. Slot data comes from an external slot RAM over a synchronous read port, replacing a flat 4104-bit input bus.
- Break, MAB, inter-slot mark (MBS) and refresh period are runtime-programmable. Single-shot and continuous modes are supported.
- The engine reports frame status. Bit timing is exact: every bit lasts BIT_TICKS cycles.
- Sits between the DMX slot buffer/arbiter and the RS-485 driver (tx/DE pins).

Parameters:
- CLK_FREQ, 12000000, system clock in Hz.
- BAUD_RATE, 250000, line rate; BIT_TICKS = CLK_FREQ/BAUD_RATE (48 at default).
- MAX_SLOTS, 513, max slots per frame including the start code; ADDR_W = clog2(MAX_SLOTS).
- MIN_BREAK_US, 92, lower clamp on the break length.
- MIN_MAB_US, 12, lower clamp on the MAB length.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_en  in  1  level; 1 = frames allowed
- one_shot  in  1  1 = send one frame per trigger; 0 = continuous
- trigger  in  1  one-cycle pulse; starts a frame when one_shot=1
- n_slots  in  10  slots to send incl. start code; 0 treated as 1; >MAX_SLOTS clamped
- break_us  in  10  break length in µs
- mab_us  in  8  MAB length in µs
- mbs_bits  in  4  extra idle-high bit times between slots
- period_cyc  in  24  frame-start to frame-start period in clk cycles
- rd_en  out  1  slot RAM read strobe
- rd_addr  out  ADDR_W  slot index
- rd_data  in  8  valid the cycle after rd_en
- tx  out  1  DMX line
- de  out  1  RS-485 driver enable
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last stop bit
- slot_idx  out  ADDR_W  slot currently on the line

Behaviour:
- Reset (async): tx=1, de=0, busy=0, frame_done=0, rd_en=0, rd_addr=0, slot_idx=0, state=IDLE, period counter=0. Asserting reset mid-frame aborts the frame immediately.
- TPU = CLK_FREQ/1000000.
- Break length = max(break_us, MIN_BREAK_US)*TPU cycles. MAB length = max(mab_us, MIN_MAB_US)*TPU cycles.
- All config inputs (n_slots, break_us, mab_us, mbs_bits) are latched at frame start; changes during a frame take effect next frame.
- States:
  - IDLE: tx=1. Start a frame when tx_en=1 and either (one_shot=0 and period counter expired) or (one_shot=1 and trigger). On start: latch config, set busy=1, clear the period counter, go to BREAK.
  - BREAK: tx=0 for the break length, then MAB.
  - MAB: tx=1 for the MAB length. Issue rd_en with rd_addr=0 two cycles before MAB ends; capture rd_data into the shift register.
  - START: tx=0 for BIT_TICKS.
  - DATA: 8 bits, LSB first, BIT_TICKS each.
  - STOP: tx=1 for 2*BIT_TICKS. In the first stop-bit cycle, issue rd_en for the next slot if one remains. At the end of STOP, go to MBS if mbs_bits>0, else START, else FRAME_END when slots are exhausted.
  - MBS: tx=1 for mbs_bits*BIT_TICKS, then START.
  - FRAME_END: frame_done=1 for one cycle, busy=0, go to IDLE.
- The period counter runs continuously while tx_en=1 and saturates at period_cyc.
  - If a frame outlasts the period, the next frame starts on the first IDLE cycle.
  - IDLE always lasts at least 1 cycle (minimum MBB).
- tx_en falling mid-frame: the current frame completes, then the engine holds IDLE.
- trigger during busy: ignored, not queued.
- de = 1 from frame start until frame_done, and also while in IDLE with tx_en=1 and one_shot=0. de = 0 otherwise.
- slot_idx updates at each START entry.
- rd_addr never exceeds latched n_slots-1.

Decomposition:
- Package dmx_pkg holds:
  - state enum (IDLE, BREAK, MAB, START, DATA, STOP, MBS, FRAME_END)
  - BIT_TICKS, TPU and clamp functions
  - ADDR_W computation
- Sub-module dmx_tick_timer: loadable down-counter with a done pulse. One instance is shared by all timed states.

Test Plan:
- Default params, n_slots=3, RAM={00,AA,55}, break_us=100, mab_us=12, mbs_bits=0, one_shot=1 with trigger -> tx low 1200 cycles, high 144 cycles, then three 11-bit frames of 48 cycles/bit. Start code 00; AA sent LSB-first as 0,1,0,1,0,1,0,1; frame_done pulses once; de high for the whole frame.
- break_us=50, mab_us=4 -> break measures 92*12=1104 cycles and MAB 144 cycles (clamped).
- n_slots=600 -> exactly 513 slots sent; rd_addr max 512. n_slots=0 -> only the start code is sent.
- Continuous mode, period_cyc=10000, n_slots=2 -> frame starts exactly 10000 cycles apart. period_cyc=100 with n_slots=513 -> frames back-to-back with 1 idle cycle between them.
- mbs_bits=3 -> 144 extra high cycles between slots.
- tx_en dropped mid-slot 5 of 10 -> frame finishes; de falls after frame_done; no new break.
- Reset pulsed during DATA -> tx=1 and de=0 immediately; the next frame after reset starts with a full break.

Source files
------------

// File: rtl/dmx_pkg.sv
// Shared types, constants and helpers for the DMX512 transmit engine.
package dmx_pkg;

    // Line-level phases of a DMX frame.
    typedef enum logic [2:0] {
        IDLE,
        BREAK,
        MAB,
        START,
        DATA,
        STOP,
        MBS,
        FRAME_END
    } dmx_state_t;

    localparam int DEF_CLK_FREQ    = 12000000;
    localparam int DEF_BAUD_RATE   = 250000;
    localparam int DEF_MAX_SLOTS   = 513;
    localparam int DEF_MIN_BREAK_US = 92;
    localparam int DEF_MIN_MAB_US  = 12;

    // Width of the down-counter shared by every timed phase.
    localparam int TMR_W = 24;

    // Clock cycles per DMX bit.
    function automatic int dmx_bit_ticks(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Clock cycles per microsecond.
    function automatic int dmx_tpu(input int clk_freq);
        return clk_freq / 1000000;
    endfunction

    // Slot index width; never narrower than one bit.
    function automatic int dmx_addr_w(input int max_slots);
        return (max_slots <= 2) ? 1 : $clog2(max_slots);
    endfunction

    // Raise a programmed duration to its legal minimum.
    function automatic int dmx_clamp_min(input int value, input int lo);
        return (value < lo) ? lo : value;
    endfunction

    // A frame always carries the start code and never exceeds the buffer.
    function automatic int dmx_clamp_slots(input int n, input int max_slots);
        if (n == 0)
            return 1;
        else if (n > max_slots)
            return max_slots;
        else
            return n;
    endfunction

endpackage

// File: rtl/dmx_tick_timer.sv
// Loadable down-counter; done is high once the count has reached zero.
// A phase loaded with length-1 therefore lasts exactly length cycles.
module dmx_tick_timer
    import dmx_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    // Reload on request, otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/dmx_tx_engine.sv
// DMX512 transmitter: break / MAB / slots framing, slot RAM fetch,
// programmable timing, single-shot and continuous refresh.
module dmx_tx_engine
    import dmx_pkg::*;
#(
    parameter int  CLK_FREQ     = DEF_CLK_FREQ,
    parameter int  BAUD_RATE    = DEF_BAUD_RATE,
    parameter int  MAX_SLOTS    = DEF_MAX_SLOTS,
    parameter int  MIN_BREAK_US = DEF_MIN_BREAK_US,
    parameter int  MIN_MAB_US   = DEF_MIN_MAB_US,
    localparam int ADDR_W       = dmx_addr_w(MAX_SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic              one_shot,
    input  logic              trigger,
    input  logic [9:0]        n_slots,
    input  logic [9:0]        break_us,
    input  logic [7:0]        mab_us,
    input  logic [3:0]        mbs_bits,
    input  logic [23:0]       period_cyc,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              de,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] slot_idx
);

    localparam int BIT_TICKS = dmx_bit_ticks(CLK_FREQ, BAUD_RATE);
    localparam int TPU       = dmx_tpu(CLK_FREQ);
    // One extra bit so "one past the last slot" is representable.
    localparam int SLOT_W    = ADDR_W + 1;

    localparam logic [TMR_W-1:0] BIT_LEN  = TMR_W'(BIT_TICKS);
    localparam logic [TMR_W-1:0] STOP_LEN = TMR_W'(2 * BIT_TICKS);

    dmx_state_t        state;
    logic [7:0]        shreg;
    logic [2:0]        bit_cnt;
    logic [SLOT_W-1:0] next_slot;
    logic [SLOT_W-1:0] n_lat;
    logic [TMR_W-1:0]  mab_len;
    logic [TMR_W-1:0]  mbs_len;
    logic              rd_pend;
    logic [23:0]       pcnt;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_len;
    logic [TMR_W-1:0]  tmr_cnt;
    logic              tmr_done;

    logic [TMR_W-1:0]  brk_len_in;
    logic [TMR_W-1:0]  mab_len_in;
    logic [TMR_W-1:0]  mbs_len_in;
    logic              period_expired;
    logic              start_frame;
    logic              more_slots;

    assign brk_len_in = TMR_W'(dmx_clamp_min(32'(break_us), MIN_BREAK_US) * TPU);
    assign mab_len_in = TMR_W'(dmx_clamp_min(32'(mab_us), MIN_MAB_US) * TPU);
    assign mbs_len_in = TMR_W'(32'(mbs_bits) * BIT_TICKS);

    // The frame starting now will be period_cyc cycles after the previous one.
    assign period_expired = ({1'b0, pcnt} + 25'd1) >= {1'b0, period_cyc};
    assign start_frame    = (state == IDLE) && tx_en &&
                            (one_shot ? trigger : period_expired);
    assign more_slots     = (next_slot < n_lat);

    // Length of the phase being entered; the timer is loaded with length-1.
    always_comb begin
        tmr_len = BIT_LEN;
        case (state)
            IDLE:    tmr_len = brk_len_in;
            BREAK:   tmr_len = mab_len;
            DATA:    if (bit_cnt == 3'd7) tmr_len = STOP_LEN;
            STOP:    if (more_slots && (mbs_len != '0)) tmr_len = mbs_len;
            default: tmr_len = BIT_LEN;
        endcase
    end

    // Reload the timer on every phase change; FRAME_END and IDLE are untimed.
    always_comb begin
        tmr_load = 1'b0;
        if (start_frame)
            tmr_load = 1'b1;
        else if ((state != IDLE) && (state != FRAME_END) && tmr_done)
            tmr_load = 1'b1;
    end

    dmx_tick_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_len - TMR_W'(1)),
        .count    (tmr_cnt),
        .done     (tmr_done)
    );

    // Refresh period counter: free-runs while enabled, saturates, restarts per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pcnt <= '0;
        else if (start_frame)
            pcnt <= '0;
        else if (tx_en && (pcnt < period_cyc))
            pcnt <= pcnt + 24'd1;
    end

    // Frame sequencer with registered line, enable, RAM and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            de         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            slot_idx   <= '0;
            rd_pend    <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            next_slot  <= '0;
            n_lat      <= '0;
            mab_len    <= '0;
            mbs_len    <= '0;
        end else begin
            rd_en      <= 1'b0;
            frame_done <= 1'b0;
            rd_pend    <= rd_en;

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (start_frame) begin
                        state     <= BREAK;
                        tx        <= 1'b0;
                        de        <= 1'b1;
                        busy      <= 1'b1;
                        n_lat     <= SLOT_W'(dmx_clamp_slots(32'(n_slots), MAX_SLOTS));
                        mab_len   <= mab_len_in;
                        mbs_len   <= mbs_len_in;
                        next_slot <= '0;
                    end else begin
                        de <= tx_en & ~one_shot;
                    end
                end

                BREAK: begin
                    if (tmr_done) begin
                        state <= MAB;
                        tx    <= 1'b1;
                    end
                end

                MAB: begin
                    // Fetch the start code so it is in the shifter when MAB ends.
                    if (tmr_cnt == TMR_W'(2)) begin
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                    end
                    if (tmr_done) begin
                        state     <= START;
                        tx        <= 1'b0;
                        slot_idx  <= '0;
                        next_slot <= SLOT_W'(1);
                    end
                end

                START: begin
                    if (tmr_done) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= '0;
                    end
                end

                DATA: begin
                    if (tmr_done) begin
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                            if (more_slots) begin
                                rd_en   <= 1'b1;
                                rd_addr <= next_slot[ADDR_W-1:0];
                            end
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                STOP: begin
                    if (tmr_done) begin
                        if (!more_slots) begin
                            state      <= FRAME_END;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end else if (mbs_len != '0) begin
                            state <= MBS;
                            tx    <= 1'b1;
                        end else begin
                            state     <= START;
                            tx        <= 1'b0;
                            slot_idx  <= next_slot[ADDR_W-1:0];
                            next_slot <= next_slot + SLOT_W'(1);
                        end
                    end
                end

                MBS: begin
                    if (tmr_done) begin
                        state     <= START;
                        tx        <= 1'b0;
                        slot_idx  <= next_slot[ADDR_W-1:0];
                        next_slot <= next_slot + SLOT_W'(1);
                    end
                end

                FRAME_END: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    de    <= tx_en & ~one_shot;
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase

            // Read data arrives one cycle after the strobe; the shifter is idle then.
            if (rd_pend)
                shreg <= rd_data;
        end
    end

endmodule

// File: tb/tb_dmx_tx_engine.sv
// Directed bench for dmx_tx_engine (default timing, 16-slot buffer).
module tb_dmx_tx_engine;

    localparam int MAXS = 16;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_en, one_shot, trigger;
    logic [9:0]    n_slots, break_us;
    logic [7:0]    mab_us;
    logic [3:0]    mbs_bits;
    logic [23:0]   period_cyc;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          tx, de, busy, frame_done;
    logic [AW-1:0] slot_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    int rd_cnt  = 0;
    int max_addr = 0;
    int fd_cnt  = 0;
    int rise_cnt = 0;
    int rise_t [0:63];
    logic busy_q = 1'b0;
    logic [7:0] ram [0:MAXS-1];

    always #5 clk = ~clk;

    dmx_tx_engine #(
        .MAX_SLOTS (MAXS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .one_shot   (one_shot),
        .trigger    (trigger),
        .n_slots    (n_slots),
        .break_us   (break_us),
        .mab_us     (mab_us),
        .mbs_bits   (mbs_bits),
        .period_cyc (period_cyc),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx         (tx),
        .de         (de),
        .busy       (busy),
        .frame_done (frame_done),
        .slot_idx   (slot_idx)
    );

    // Slot RAM model plus cycle, read, frame_done and frame-start monitors.
    always @(posedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (rd_en === 1'b1) begin
            rd_data <= ram[rd_addr];
            rd_cnt = rd_cnt + 1;
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
        end
        if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
        if (busy === 1'b1 && busy_q === 1'b0) begin
            if (rise_cnt < 64) rise_t[rise_cnt] = cyc_cnt;
            rise_cnt = rise_cnt + 1;
        end
        busy_q = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_trigger();
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic measure(input logic v, output int n);
        n = 0;
        while (tx === v && n < 20000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic rx_byte(output logic [7:0] b, output int t0, output logic stop_bit);
        int n;
        n = 0;
        b = 8'h00;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc_cnt;
        cyc(24);
        for (int i = 0; i < 8; i++) begin
            cyc(48);
            b[i] = tx;
        end
        cyc(48);
        stop_bit = tx;
    endtask

    task automatic wait_fd(input string tag, input int lim);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(tag, frame_done, 1);
    endtask

    task automatic wait_slot(input int s, input int lim);
        int n;
        n = 0;
        while (int'(slot_idx) != s && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rises(input int target, input int lim);
        int n;
        n = 0;
        while (rise_cnt < target && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [7:0] b;
        logic       sb;
        int         t0, t1, t2, n, base;

        for (int i = 0; i < MAXS; i++) ram[i] = 8'(i * 17 + 3);
        ram[0] = 8'h00;
        ram[1] = 8'hAA;
        ram[2] = 8'h55;

        tx_en = 1'b0; one_shot = 1'b1; trigger = 1'b0;
        n_slots = 10'd3; break_us = 10'd100; mab_us = 8'd12; mbs_bits = 4'd0;
        period_cyc = 24'hFFFFFF;

        // Reset state
        cyc(3);
        check("rst_tx", tx, 1);
        check("rst_de", de, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_slot_idx", slot_idx, 0);
        rst_n = 1'b1;
        tx_en = 1'b1;
        cyc(5);
        check("idle_de_oneshot", de, 0);
        check("idle_tx", tx, 1);

        // Single-shot frame, 3 slots
        fd_cnt = 0; rd_cnt = 0;
        pulse_trigger();
        check("t1_busy", busy, 1);
        check("t1_de_start", de, 1);
        measure(1'b0, n);
        check("t1_break_len", n, 1200);
        measure(1'b1, n);
        check("t1_mab_len", n, 144);
        rx_byte(b, t0, sb);
        check("t1_slot0", b, 8'h00);
        check("t1_slot0_stop", sb, 1);
        rx_byte(b, t1, sb);
        check("t1_slot1", b, 8'hAA);
        check("t1_slot_idx1", slot_idx, 1);
        check("t1_slot_period_a", t1 - t0, 528);
        check("t1_de_mid", de, 1);
        rx_byte(b, t2, sb);
        check("t1_slot2", b, 8'h55);
        check("t1_slot_period_b", t2 - t1, 528);
        wait_fd("t1_frame_done", 1000);
        check("t1_de_at_done", de, 1);
        cyc(1);
        check("t1_de_after_done", de, 0);
        cyc(50);
        check("t1_fd_count", fd_cnt, 1);
        check("t1_rd_count", rd_cnt, 3);
        check("t1_busy_end", busy, 0);

        // Clamped break/MAB, n_slots=0 -> start code only
        break_us = 10'd50; mab_us = 8'd4; n_slots = 10'd0; rd_cnt = 0;
        pulse_trigger();
        measure(1'b0, n);
        check("t2_break_clamp", n, 1104);
        measure(1'b1, n);
        check("t2_mab_clamp", n, 144);
        rx_byte(b, t0, sb);
        check("t2_start_code", b, 8'h00);
        wait_fd("t2_frame_done", 1000);
        check("t2_rd_count", rd_cnt, 1);

        // n_slots above buffer size is clamped to MAXS
        break_us = 10'd100; mab_us = 8'd12; n_slots = 10'd600;
        rd_cnt = 0; max_addr = 0;
        cyc(5);
        pulse_trigger();
        wait_fd("t3_frame_done", 12000);
        check("t3_rd_count", rd_cnt, MAXS);
        check("t3_max_addr", max_addr, MAXS - 1);
        check("t3_last_slot_idx", slot_idx, MAXS - 1);

        // Continuous mode, period 10000, 2 slots
        n_slots = 10'd2; period_cyc = 24'd10000;
        base = rise_cnt;
        one_shot = 1'b0;
        wait_fd("t4_frame_done", 4000);
        cyc(2);
        check("t4_idle_de_cont", de, 1);
        check("t4_idle_busy", busy, 0);
        wait_rises(base + 2, 12000);
        check("t4_period", rise_t[base + 1] - rise_t[base], 10000);

        // Frame longer than period -> back-to-back with 1 idle cycle
        period_cyc = 24'd100;
        base = rise_cnt;
        wait_rises(base + 2, 8000);
        check("t4_back_to_back", rise_t[base + 1] - rise_t[base], 2402);

        // Inter-slot mark of 3 bits
        one_shot = 1'b1; period_cyc = 24'hFFFFFF;
        wait_fd("t5_prev_frame_done", 3000);
        cyc(3);
        mbs_bits = 4'd3; n_slots = 10'd2;
        pulse_trigger();
        measure(1'b0, n);
        check("t5_break_len", n, 1200);
        measure(1'b1, n);
        check("t5_mab_len", n, 144);
        rx_byte(b, t0, sb);
        rx_byte(b, t1, sb);
        check("t5_slot1", b, 8'hAA);
        check("t5_slot_period_mbs", t1 - t0, 672);
        wait_fd("t5_frame_done", 1000);

        // tx_en dropped during slot 5 of 10 in continuous mode
        mbs_bits = 4'd0; n_slots = 10'd10; period_cyc = 24'd100;
        rd_cnt = 0;
        one_shot = 1'b0;
        wait_slot(5, 8000);
        check("t6_reached_slot5", slot_idx, 5);
        tx_en = 1'b0;
        wait_fd("t6_frame_done", 8000);
        check("t6_de_at_done", de, 1);
        check("t6_rd_count", rd_cnt, 10);
        cyc(1);
        check("t6_de_after_done", de, 0);
        base = rise_cnt;
        cyc(3000);
        check("t6_no_new_frame", rise_cnt, base);
        check("t6_tx_idle", tx, 1);
        check("t6_busy_idle", busy, 0);

        // Reset asserted mid-DATA, then a fresh frame
        tx_en = 1'b1; one_shot = 1'b1; n_slots = 10'd3;
        cyc(3);
        pulse_trigger();
        wait_slot(1, 3000);
        cyc(100);
        rst_n = 1'b0;
        #1;
        check("t7_rst_tx", tx, 1);
        check("t7_rst_de", de, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_slot_idx", slot_idx, 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        pulse_trigger();
        measure(1'b0, n);
        check("t7_full_break", n, 1200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
